// File: rtl/sm_out_if.sv
// sm_collector result stream toward the host/DMA side.
// Show-ahead FIFO head with valid/ready and occupancy.
interface sm_out_if #(
  parameter int DW = 64,
  parameter int CW = 4
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;

  modport master (
    output out_valid,
    output out_data,
    output out_count,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_count,
    output out_ready
  );
endinterface

// File: rtl/sm_collector.sv
// sm_collector: pairs per-channel final scores with FIFO IDs,
// filters on threshold and queues {id, score} records.
module sm_collector #(
  parameter int ID_WIDTH    = 48,
  parameter int SCORE_WIDTH = 16,
  parameter int MIN_SCORE   = 0,
  parameter int OUT_DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   done0,
  input  logic                   done1,
  input  logic [SCORE_WIDTH-1:0] score0,
  input  logic [SCORE_WIDTH-1:0] score1,
  input  logic [ID_WIDTH-1:0]    id0,
  input  logic [ID_WIDTH-1:0]    id1,
  output logic                   re0,
  output logic                   re1,
  sm_out_if.master               res,
  output logic [1:0]             overrun,
  output logic [15:0]            drop_cnt
);

  localparam int DW = ID_WIDTH + SCORE_WIDTH;
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  logic                   pend0;
  logic                   pend1;
  logic [SCORE_WIDTH-1:0] pscore0;
  logic [SCORE_WIDTH-1:0] pscore1;
  logic                   last;
  logic                   below0;
  logic                   below1;
  logic                   room;
  logic                   el0;
  logic                   el1;
  logic                   g0;
  logic                   g1;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [DW-1:0]          wdata;
  logic [DW-1:0]          mem [OUT_DEPTH];
  logic [PW-1:0]          wp;
  logic [PW-1:0]          rp;
  logic [CW-1:0]          count;

  // A zero threshold can never drop, so no compare is built.
  if (MIN_SCORE > 0) begin : g_thr
    localparam logic [SCORE_WIDTH-1:0] MINV =
      SCORE_WIDTH'(MIN_SCORE);
    assign below0 = pscore0 < MINV;
    assign below1 = pscore1 < MINV;
  end else begin : g_nothr
    assign below0 = 1'b0;
    assign below1 = 1'b0;
  end

  // Eligibility and round-robin grant; full uses registered count.
  always_comb begin
    room  = count < CW'(OUT_DEPTH);
    el0   = pend0 && (below0 || room);
    el1   = pend1 && (below1 || room);
    g0    = el0 && (!el1 || last);
    g1    = el1 && (!el0 || !last);
    re0   = g0;
    re1   = g1;
    push  = (g0 && !below0) || (g1 && !below1);
    drop  = (g0 && below0) || (g1 && below1);
    wdata = g0 ? {id0, pscore0} : {id1, pscore1};
    pop   = res.out_valid && res.out_ready;
  end

  // Per-channel pending score capture and overrun detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend0   <= 1'b0;
      pend1   <= 1'b0;
      pscore0 <= '0;
      pscore1 <= '0;
      overrun <= 2'b00;
      last    <= 1'b1;
    end else begin
      if (done0 && (!pend0 || g0)) begin
        pend0   <= 1'b1;
        pscore0 <= score0;
      end else if (g0) begin
        pend0 <= 1'b0;
      end
      if (done0 && pend0 && !g0)
        overrun[0] <= 1'b1;
      if (done1 && (!pend1 || g1)) begin
        pend1   <= 1'b1;
        pscore1 <= score1;
      end else if (g1) begin
        pend1 <= 1'b0;
      end
      if (done1 && pend1 && !g1)
        overrun[1] <= 1'b1;
      if (g0)
        last <= 1'b0;
      else if (g1)
        last <= 1'b1;
    end
  end

  // Saturating count of below-threshold results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)
        wp <= wp + PW'(1);
      if (pop)
        rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Record storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= wdata;
  end

  assign res.out_valid = count != '0;
  assign res.out_count = count;
  assign res.out_data  = mem[rp];

endmodule
